// File: rtl/fifo_pkg.sv
// fifo_pkg: shared read-mode constants and width helper for the FIFO blocks
package fifo_pkg;
  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;
  function automatic int cnt_w(input int depth);
    return depth + 1;
  endfunction
endpackage

// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp: 2**DEPTH x WIDTH storage, sync write, registered or asynchronous read
module fifo_mem_dp #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 3,
  parameter bit REG_RD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [DEPTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  generate
    if (REG_RD) begin : g_bram
      (* ram_style = "block" *) logic [WIDTH-1:0] mem [2**DEPTH];
      always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
      // only the output register is reset; the array keeps its contents
      always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
      end
    end else begin : g_lut
      logic [WIDTH-1:0] mem [2**DEPTH];
      logic unused_ok;
      always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
      assign rdata     = mem[raddr];
      assign unused_ok = ^{rst, re};
    end
  endgenerate
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with standard/FWFT read, count, thresholds and sticky errors
module sync_fifo import fifo_pkg::*; #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 3,
  parameter int FWFT      = FIFO_STD,
  parameter int AFULL_TH  = 2**DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        din,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        dout,
  output logic                    valid,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    overflow,
  output logic                    underflow
);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] CAP = CW'(2**DEPTH);
  localparam logic [CW-1:0] AF  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE  = CW'(AEMPTY_TH);
  logic [DEPTH-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d, valid_q;
  logic             wr_acc, rd_acc;
  // flags decode from the count register alone, so no input reaches them combinationally
  assign empty        = count_q == '0;
  assign full         = count_q == CAP;
  assign almost_full  = count_q >= AF;
  assign almost_empty = count_q <= AE;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign valid        = (FWFT == FIFO_FWFT) ? !empty : valid_q;
  always_comb begin
    wr_acc  = wr_en && !full;
    rd_acc  = rd_en && !empty;
    waddr_d = wr_acc ? waddr_q + 1'b1 : waddr_q;
    raddr_d = rd_acc ? raddr_q + 1'b1 : raddr_q;
    count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    ovf_d   = ovf_q || (wr_en && full);
    udf_d   = udf_q || (rd_en && empty);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q <= '0;
      raddr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      valid_q <= rd_acc;
    end
  end
  fifo_mem_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .REG_RD(FWFT == FIFO_STD)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_acc && !rst),
    .waddr(waddr_q),
    .wdata(din),
    .re   (rd_acc && !rst),
    .raddr(raddr_q),
    .rdata(dout)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed checks of standard and FWFT FIFO instances
module tb_sync_fifo;
  logic        clk = 0, rst = 0;
  logic        s_wr = 0, s_rd = 0, f_wr = 0, f_rd = 0;
  logic [15:0] s_din = 0, f_din = 0, s_dout, f_dout;
  logic        s_valid, s_empty, s_full, s_af, s_ae, s_ovf, s_udf;
  logic        f_valid, f_empty, f_full, f_af, f_ae, f_ovf, f_udf;
  logic [3:0]  s_count, f_count;
  int pass = 0, total = 0;

  always #5 clk = ~clk;

  sync_fifo #(.WIDTH(16), .DEPTH(3), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(s_wr), .din(s_din), .rd_en(s_rd), .dout(s_dout),
    .valid(s_valid), .empty(s_empty), .full(s_full), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_udf));

  sync_fifo #(.WIDTH(16), .DEPTH(3), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr), .din(f_din), .rd_en(f_rd), .dout(f_dout),
    .valid(f_valid), .empty(f_empty), .full(f_full), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf));

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1; s_wr = 0; s_rd = 0; f_wr = 0; f_rd = 0;
    tick; tick;
    rst = 0;
  endtask

  task automatic test_reset;
    do_reset;
    total++; if ({s_count, s_empty, s_full, s_ae, s_af, s_valid, s_ovf, s_udf} !== {4'd0, 7'b1010000})
      $display("FAIL reset_flags got cnt=%0d e=%b f=%b ae=%b af=%b v=%b o=%b u=%b want cnt=0 e=1 f=0 ae=1 af=0 v=0 o=0 u=0",
               s_count, s_empty, s_full, s_ae, s_af, s_valid, s_ovf, s_udf); else pass++;
    total++; if (s_dout !== 16'h0) $display("FAIL reset_dout got %h want 0000", s_dout); else pass++;
    total++; if ({f_valid, f_empty} !== 2'b01) $display("FAIL reset_fwft got v=%b e=%b want v=0 e=1", f_valid, f_empty); else pass++;
  endtask

  task automatic test_underflow;
    s_rd = 1; tick; s_rd = 0;
    total++; if (s_udf !== 1'b1) $display("FAIL underflow_flag got %b want 1", s_udf); else pass++;
    total++; if ({s_valid, s_dout, s_count} !== {1'b0, 16'h0, 4'd0})
      $display("FAIL underflow_data got v=%b d=%h c=%0d want v=0 d=0000 c=0", s_valid, s_dout, s_count); else pass++;
    tick;
    total++; if (s_udf !== 1'b1) $display("FAIL underflow_sticky got %b want 1", s_udf); else pass++;
  endtask

  task automatic test_fill_drain;
    do_reset;
    s_wr = 1;
    for (int i = 1; i <= 8; i++) begin
      s_din = 16'(i); tick;
      total++; if (s_count !== 4'(i)) $display("FAIL fill_count got %0d want %0d", s_count, i); else pass++;
      total++; if (s_af !== (i >= 6)) $display("FAIL fill_afull at %0d got %b want %b", i, s_af, i >= 6); else pass++;
      total++; if (s_ae !== (i <= 2)) $display("FAIL fill_aempty at %0d got %b want %b", i, s_ae, i <= 2); else pass++;
    end
    total++; if ({s_full, s_ovf} !== 2'b10) $display("FAIL fill_full got f=%b o=%b want f=1 o=0", s_full, s_ovf); else pass++;
    s_din = 16'h9; tick; s_wr = 0;
    total++; if ({s_ovf, s_count} !== {1'b1, 4'd8}) $display("FAIL overflow got o=%b c=%0d want o=1 c=8", s_ovf, s_count); else pass++;
    for (int i = 1; i <= 8; i++) begin
      s_rd = 1; tick; s_rd = 0;
      total++; if ({s_valid, s_dout} !== {1'b1, 16'(i)}) $display("FAIL drain_read got v=%b d=%h want v=1 d=%h", s_valid, s_dout, 16'(i)); else pass++;
      tick;
      total++; if ({s_valid, s_dout} !== {1'b0, 16'(i)}) $display("FAIL drain_hold got v=%b d=%h want v=0 d=%h", s_valid, s_dout, 16'(i)); else pass++;
    end
    total++; if ({s_empty, s_count, s_udf} !== {1'b1, 4'd0, 1'b0}) $display("FAIL drain_empty got e=%b c=%0d u=%b want e=1 c=0 u=0", s_empty, s_count, s_udf); else pass++;
  endtask

  task automatic test_simultaneous;
    do_reset;
    s_wr = 1;
    for (int i = 1; i <= 8; i++) begin s_din = 16'h10 + 16'(i); tick; end
    s_rd = 1; s_din = 16'h55; tick;
    total++; if ({s_count, s_ovf} !== {4'd7, 1'b1}) $display("FAIL simul_full got c=%0d o=%b want c=7 o=1", s_count, s_ovf); else pass++;
    total++; if ({s_valid, s_dout} !== {1'b1, 16'h11}) $display("FAIL simul_full_data got v=%b d=%h want v=1 d=0011", s_valid, s_dout); else pass++;
    s_wr = 0;
    for (int i = 0; i < 7; i++) tick;
    total++; if ({s_count, s_dout, s_udf} !== {4'd0, 16'h18, 1'b0}) $display("FAIL simul_drain got c=%0d d=%h u=%b want c=0 d=0018 u=0", s_count, s_dout, s_udf); else pass++;
    s_wr = 1; s_din = 16'h77; tick;
    total++; if ({s_count, s_udf, s_valid} !== {4'd1, 1'b1, 1'b0}) $display("FAIL simul_empty got c=%0d u=%b v=%b want c=1 u=1 v=0", s_count, s_udf, s_valid); else pass++;
    s_wr = 0; tick; s_rd = 0;
    total++; if ({s_valid, s_dout, s_empty} !== {1'b1, 16'h77, 1'b1}) $display("FAIL simul_last got v=%b d=%h e=%b want v=1 d=0077 e=1", s_valid, s_dout, s_empty); else pass++;
  endtask

  task automatic test_wrap;
    do_reset;
    s_wr = 1; s_din = 16'd100; tick; s_din = 16'd101; tick;
    s_rd = 1;
    for (int k = 0; k < 20; k++) begin
      s_din = 16'd102 + 16'(k); tick;
      total++; if ({s_valid, s_dout} !== {1'b1, 16'd100 + 16'(k)}) $display("FAIL wrap_data k=%0d got v=%b d=%0d want v=1 d=%0d", k, s_valid, s_dout, 100 + k); else pass++;
      total++; if (s_count !== 4'd2) $display("FAIL wrap_count k=%0d got %0d want 2", k, s_count); else pass++;
    end
    s_wr = 0; s_rd = 0;
  endtask

  task automatic test_rst_mid;
    do_reset;
    s_wr = 1;
    for (int i = 1; i <= 5; i++) begin s_din = 16'(i); tick; end
    total++; if (s_count !== 4'd5) $display("FAIL rstmid_pre got %0d want 5", s_count); else pass++;
    s_rd = 1; tick; s_rd = 0;
    rst = 1; s_din = 16'hDEAD; tick; rst = 0; s_wr = 0;
    total++; if ({s_count, s_empty, s_valid, s_ovf, s_udf, s_dout} !== {4'd0, 1'b1, 3'b000, 16'h0})
      $display("FAIL rstmid got c=%0d e=%b v=%b o=%b u=%b d=%h want c=0 e=1 v=0 o=0 u=0 d=0000", s_count, s_empty, s_valid, s_ovf, s_udf, s_dout); else pass++;
    tick;
    total++; if ({s_count, s_empty} !== {4'd0, 1'b1}) $display("FAIL rstmid_discard got c=%0d e=%b want c=0 e=1", s_count, s_empty); else pass++;
  endtask

  task automatic test_fwft;
    do_reset;
    f_wr = 1; f_din = 16'hABCD; tick; f_wr = 0;
    total++; if ({f_valid, f_dout, f_count} !== {1'b1, 16'hABCD, 4'd1}) $display("FAIL fwft_write got v=%b d=%h c=%0d want v=1 d=abcd c=1", f_valid, f_dout, f_count); else pass++;
    f_rd = 1; tick; f_rd = 0;
    total++; if ({f_valid, f_empty, f_udf} !== 3'b010) $display("FAIL fwft_pop got v=%b e=%b u=%b want v=0 e=1 u=0", f_valid, f_empty, f_udf); else pass++;
    f_wr = 1; f_din = 16'h1111; tick; f_din = 16'h2222; tick; f_wr = 0;
    total++; if (f_dout !== 16'h1111) $display("FAIL fwft_head got %h want 1111", f_dout); else pass++;
    f_rd = 1; tick;
    total++; if ({f_valid, f_dout} !== {1'b1, 16'h2222}) $display("FAIL fwft_next got v=%b d=%h want v=1 d=2222", f_valid, f_dout); else pass++;
    tick; f_rd = 0;
    total++; if ({f_valid, f_empty} !== 2'b01) $display("FAIL fwft_empty got v=%b e=%b want v=0 e=1", f_valid, f_empty); else pass++;
  endtask

  initial begin
    test_reset;
    test_underflow;
    test_fill_drain;
    test_simultaneous;
    test_wrap;
    test_rst_mid;
    test_fwft;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
